// File: rtl/aes_pkg.sv
// Shared AES types, round-count constants and byte-level helper functions.
package aes_pkg;

    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    // Byte 0 is bits [127:120]; bytes are column-major.
    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } aes_state_e;

    // GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Row r (bytes r, r+4, r+8, r+12) is rotated right by r positions.
    function automatic aes_block_t inv_shiftrows(input aes_block_t b);
        aes_block_t r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(4*c+row) -: 8] = b[127-8*(4*((c-row+4)%4)+row) -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_mixcols.sv
// Combinational InvMixColumns over all four columns.
module aes_inv_mixcols
    import aes_pkg::*;
(
    input  aes_block_t data_i,
    output aes_block_t data_o
);

    // Each output byte is the {0e,0b,0d,09} circulant row applied to its column.
    always_comb begin
        data_o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                data_o[127-8*(4*c+r) -: 8] =
                    gf_mul(data_i[127-8*(4*c+r) -: 8],         8'h0e) ^
                    gf_mul(data_i[127-8*(4*c+(r+1)%4) -: 8],   8'h0b) ^
                    gf_mul(data_i[127-8*(4*c+(r+2)%4) -: 8],   8'h0d) ^
                    gf_mul(data_i[127-8*(4*c+(r+3)%4) -: 8],   8'h09);
            end
        end
    end

endmodule

// File: rtl/aes_inv_round.sv
// One inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns
// unless this is the last round.
module aes_inv_round
    import aes_pkg::*;
(
    input  aes_block_t state_i,
    input  aes_block_t key_i,
    input  logic       last_i,
    output aes_block_t result_o
);

    aes_block_t shifted;
    aes_block_t subbed;
    aes_block_t keyed;
    aes_block_t mixed;

    assign shifted = inv_shiftrows(state_i);

    for (genvar g = 0; g < 16; g++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .data_i (shifted[127-8*g -: 8]),
            .data_o (subbed[127-8*g -: 8])
        );
    end

    assign keyed = subbed ^ key_i;

    aes_inv_mixcols u_mixcols (
        .data_i (keyed),
        .data_o (mixed)
    );

    assign result_o = last_i ? keyed : mixed;

endmodule

// File: rtl/aes_inv_sbox.sv
// Inverse S-box: inverse affine transform followed by the GF(2^8) inverse (x^254).
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    logic [7:0] pre;
    logic [7:0] sq;
    logic [7:0] acc;

    // x^254 = x^2 * x^4 * ... * x^128; zero maps to zero naturally.
    always_comb begin
        pre = {data_i[6:0], data_i[7]} ^ {data_i[4:0], data_i[7:5]} ^
              {data_i[1:0], data_i[7:2]} ^ 8'h05;
        sq  = pre;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        data_o = acc;
    end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES decryption core: one round per clock, round keys looked up by index.
//
// state | meaning
// IDLE  | ready for ciphertext; initial AddRoundKey with key NR on accept
// ROUND | full inverse round with key cnt; cnt counts NR-1 down to 1
// FINAL | last round (no InvMixColumns) with key 0, result to out_data
// DONE  | plaintext valid, held until out_ready
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (NR != NR_AES128 && NR != NR_AES192 && NR != NR_AES256) begin : g_nr_check
        $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
    end

    localparam logic [3:0] NR_IDX   = 4'(NR);
    localparam logic [3:0] NR_FIRST = 4'(NR - 1);

    aes_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    aes_block_t blk_q, blk_d;
    aes_block_t out_q, out_d;
    aes_block_t round_res;

    aes_inv_round u_round (
        .state_i  (blk_q),
        .key_i    (rk_data),
        .last_i   (state_q == FINAL),
        .result_o (round_res)
    );

    // State, round counter, working block and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            blk_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            out_q   <= out_d;
        end
    end

    // Next-state, datapath selection and key index.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        out_d   = out_q;
        rk_idx  = 4'd0;
        case (state_q)
            IDLE: begin
                rk_idx = NR_IDX;
                if (in_valid) begin
                    blk_d   = in_data ^ rk_data;
                    cnt_d   = NR_FIRST;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                rk_idx = cnt_q;
                blk_d  = round_res;
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = FINAL;
            end
            FINAL: begin
                out_d   = round_res;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ROUND) || (state_q == FINAL);
    assign out_data  = out_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: FIPS-197 vectors plus random blocks produced by a
// forward-cipher reference model, on an NR=10 and an NR=14 instance.
module tb_aes_inv_cipher_iter;

    logic clk;
    logic rst_n;

    logic         tb_iv, tb_or;
    logic [127:0] tb_id;
    bit           use14;

    logic         iv10, ir10, ov10, busy10;
    logic [3:0]   rki10;
    logic [127:0] rkd10, od10;
    logic         iv14, ir14, ov14, busy14;
    logic [3:0]   rki14;
    logic [127:0] rkd14, od14;

    logic [127:0] ks10 [0:15];
    logic [127:0] ks14 [0:15];
    logic [127:0] exp_rk [0:14];
    logic [7:0]   sbox [0:255];

    logic         m_ir, m_ov, m_busy;
    logic [3:0]   m_rki;
    logic [127:0] m_od;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;

    assign iv10  = tb_iv & ~use14;
    assign iv14  = tb_iv & use14;
    assign rkd10 = ks10[rki10];
    assign rkd14 = ks14[rki14];

    assign m_ir   = use14 ? ir14   : ir10;
    assign m_ov   = use14 ? ov14   : ov10;
    assign m_busy = use14 ? busy14 : busy10;
    assign m_rki  = use14 ? rki14  : rki10;
    assign m_od   = use14 ? od14   : od10;

    aes_inv_cipher_iter #(.NR(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv10), .in_ready(ir10), .in_data(tb_id),
        .rk_idx(rki10), .rk_data(rkd10),
        .out_valid(ov10), .out_ready(tb_or), .out_data(od10),
        .busy(busy10)
    );

    aes_inv_cipher_iter #(.NR(14)) dut14 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv14), .in_ready(ir14), .in_data(tb_id),
        .rk_idx(rki14), .rk_data(rkd14),
        .out_valid(ov14), .out_ready(tb_or), .out_data(od14),
        .busy(busy14)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // ---------------- reference model (forward cipher + key expansion) ----------------
    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Walk the multiplicative group with generator 3 and its inverse in lockstep.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nk);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic load_key10(input logic [127:0] k);
        expand_key({k, 128'h0}, 4);
        for (int r = 0; r <= 10; r++) ks10[r] = exp_rk[r];
    endtask

    task automatic load_key14(input logic [255:0] k);
        expand_key(k, 8);
        for (int r = 0; r <= 14; r++) ks14[r] = exp_rk[r];
    endtask

    // Encrypts with the schedule currently in exp_rk.
    function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
        logic [7:0] s [0:15];
        logic [7:0] t [0:15];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ exp_rk[0][127-8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[row+4*c] = t[row+4*((c+row)%4)];
            if (r != nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ exp_rk[r][127-8*i -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- transaction driver ----------------
    // Called at a falling edge with the selected core idle.
    task automatic send_block(input logic [127:0] ct, input logic [127:0] pt,
                              input int nr, input int stall, input string tag);
        int  lat;
        int  exp_idx;
        bit  seen;
        use14 = (nr == 14);
        #1;
        check({tag, " idle"}, {m_ir, m_ov, m_rki}, {1'b1, 1'b0, 4'(nr)});
        tb_iv = 1'b1;
        tb_id = ct;
        tb_or = 1'b0;
        @(posedge clk);
        seen = 1'b0;
        lat  = -1;
        for (int j = 0; j < nr + 4 && !seen; j++) begin
            @(negedge clk);
            tb_iv = 1'($urandom_range(0, 1));
            tb_id = rand128();
            if (m_ov) begin
                seen = 1'b1;
                lat  = j;
            end else begin
                exp_idx = (j <= nr - 2) ? nr - 1 - j : 0;
                check({tag, " round"}, {m_busy, m_ir, m_rki}, {1'b1, 1'b0, 4'(exp_idx)});
            end
        end
        check({tag, " latency"}, lat, nr);
        tb_iv = 1'b1;
        for (int s = 0; s < stall; s++) begin
            check({tag, " hold"}, {m_ov, m_ir, m_busy, m_od}, {1'b1, 1'b0, 1'b0, pt});
            tb_id = rand128();
            @(negedge clk);
        end
        check({tag, " plaintext"}, {m_ov, m_od}, {1'b1, pt});
        tb_or = 1'b1;
        tb_iv = 1'b0;
        @(negedge clk);
        tb_or = 1'b0;
        check({tag, " release"}, {m_ov, m_ir, m_busy}, {1'b0, 1'b1, 1'b0});
    endtask

    logic [127:0] r_pt, r_ct, r_k;
    logic [255:0] r_k256;
    logic [127:0] outs [0:1];
    int           acc_t [0:1];
    int           nacc, nout;
    bit           ov_seen;

    initial begin
        rst_n = 1'b0;
        tb_iv = 1'b0;
        tb_id = '0;
        tb_or = 1'b0;
        use14 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ks10[i] = '0;
            ks14[i] = '0;
        end
        build_sbox();

        // Reset and idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset ctrl", {ir10, ov10, busy10, rki10}, {1'b1, 1'b0, 1'b0, 4'd10});
        check("reset out_data", od10, 128'h0);
        check("reset rk_idx nr14", {ir14, ov14, rki14}, {1'b1, 1'b0, 4'd14});
        @(negedge clk);

        // FIPS-197 vectors
        load_key10(KEY_B);
        send_block(CT_B, PT_B, 10, 0, "fips_b");
        load_key10(KEY_C1);
        send_block(CT_C1, PT_C, 10, 5, "fips_c1");
        load_key14(KEY_C3);
        send_block(CT_C3, PT_C, 14, 1, "fips_c3");

        // Reset in the middle of a block
        use14 = 1'b0;
        load_key10(KEY_B);
        #1;
        tb_iv = 1'b1;
        tb_id = CT_B;
        @(posedge clk);
        @(negedge clk);
        tb_iv = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mid busy", {m_busy, m_rki}, {1'b1, 4'd5});
        rst_n = 1'b0;
        #1;
        check("rst_mid values", {m_ov, m_busy, m_ir, m_rki, m_od},
              {1'b0, 1'b0, 1'b1, 4'd10, 128'h0});
        ov_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (m_ov) ov_seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (m_ov) ov_seen = 1'b1;
        end
        check("rst_mid no out_valid", ov_seen, 1'b0);
        load_key10(KEY_C1);
        send_block(CT_C1, PT_C, 10, 0, "after_rst");

        // Back-to-back with in_valid and out_ready held high
        use14 = 1'b0;
        load_key10(KEY_B);
        #1;
        tb_id = CT_B;
        tb_iv = 1'b1;
        tb_or = 1'b1;
        nacc = 0;
        nout = 0;
        acc_t[0] = 0;
        acc_t[1] = 0;
        outs[0] = '0;
        outs[1] = '0;
        for (int c = 0; c < 40 && nout < 2; c++) begin
            if (m_ir && tb_iv && nacc < 2) begin
                acc_t[nacc] = c;
                nacc++;
            end
            if (m_ov) begin
                outs[nout] = m_od;
                nout++;
                load_key10(KEY_C1);
                tb_id = CT_C1;
                if (nout == 2) tb_iv = 1'b0;
            end else if (!m_ir) begin
                tb_id = rand128();
            end
            @(negedge clk);
        end
        tb_iv = 1'b0;
        tb_or = 1'b0;
        check("b2b count", {nacc[3:0], nout[3:0]}, {4'd2, 4'd2});
        check("b2b first", outs[0], PT_B);
        check("b2b second", outs[1], PT_C);
        check("b2b spacing", acc_t[1] - acc_t[0], 12);
        @(negedge clk);

        // Random blocks against the forward-cipher model
        for (int n = 0; n < 3; n++) begin
            r_k  = rand128();
            r_pt = rand128();
            load_key10(r_k);
            r_ct = encrypt(r_pt, 10);
            send_block(r_ct, r_pt, 10, $urandom_range(0, 2), "rand128");
        end
        for (int n = 0; n < 3; n++) begin
            r_k256 = {rand128(), rand128()};
            r_pt   = rand128();
            load_key14(r_k256);
            r_ct = encrypt(r_pt, 14);
            send_block(r_ct, r_pt, 14, $urandom_range(0, 2), "rand256");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
